mci_port_arbiter: RTL

- Merges the CPU's two memory ports onto one memory-side port: port 1 carries instruction fetch and port 2 carries data load/store.
- Sits directly downstream of the CPU core.
- Registers one request per cycle toward memory and records which port owns each issued request.
- Routes the in-order memory responses back to the owning port.

---
 rtl/mci_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mci_port_arbiter.sv
// Merges the CPU instruction-fetch port (P1) and data port (P2) onto one memory port.
// Records the owner of each issued request and routes in-order responses back to it.
module mci_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_W-1:0]     p1_req_addr,
    input  logic                  p1_req_we,
    input  logic [DATA_W/8-1:0]   p1_req_wstrb,
    input  logic [DATA_W-1:0]     p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_W-1:0]     p1_rsp_rdata,

    input  logic                  p2_req_valid,
    output logic                  p2_req_ready,
    input  logic [ADDR_W-1:0]     p2_req_addr,
    input  logic                  p2_req_we,
    input  logic [DATA_W/8-1:0]   p2_req_wstrb,
    input  logic [DATA_W-1:0]     p2_req_wdata,
    output logic                  p2_rsp_valid,
    output logic [DATA_W-1:0]     p2_rsp_rdata,

    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [ADDR_W-1:0]     m_req_addr,
    output logic                  m_req_we,
    output logic [DATA_W/8-1:0]   m_req_wstrb,
    output logic [DATA_W-1:0]     m_req_wdata,
    input  logic                  m_rsp_valid,
    input  logic [DATA_W-1:0]     m_rsp_rdata,

    output logic                  o_err_unexpected
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W:0] MAX_CNT = MAX_OUTSTANDING[CNT_W:0];
    localparam logic PORT_P1 = 1'b0;
    localparam logic PORT_P2 = 1'b1;

    logic                 last_grant;
    logic                 slot_port;
    logic                 grant;
    logic [CNT_W-1:0]     fifo_count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [MAX_OUTSTANDING-1:0] route_id;
    logic                 fifo_empty;
    logic                 head;
    logic                 push;
    logic                 pop;
    logic                 slot_free;
    logic                 can_issue;
    logic                 accept;
    logic [CNT_W:0]       outstanding;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_we;
    logic [STRB_W-1:0]    sel_wstrb;
    logic [DATA_W-1:0]    sel_wdata;

    assign fifo_empty = (fifo_count == '0);
    assign head       = route_id[rd_ptr];
    assign push       = m_req_valid && m_req_ready;
    assign pop        = m_rsp_valid && !fifo_empty;
    assign slot_free  = !m_req_valid || m_req_ready;

    // A draining slot only moves its entry into the route FIFO, so it frees no credit.
    assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, m_req_valid};
    assign can_issue   = slot_free && (outstanding < MAX_CNT);

    always_comb begin
        grant = PORT_P1;
        if (p1_req_valid && p2_req_valid) begin
            grant = ~last_grant;
        end else if (p2_req_valid) begin
            grant = PORT_P2;
        end
    end

    assign p1_req_ready = can_issue && (grant == PORT_P1);
    assign p2_req_ready = can_issue && (grant == PORT_P2);
    assign accept = (p1_req_valid && p1_req_ready) || (p2_req_valid && p2_req_ready);

    assign sel_addr  = (grant == PORT_P2) ? p2_req_addr  : p1_req_addr;
    assign sel_we    = (grant == PORT_P2) ? p2_req_we    : p1_req_we;
    assign sel_wstrb = (grant == PORT_P2) ? p2_req_wstrb : p1_req_wstrb;
    assign sel_wdata = (grant == PORT_P2) ? p2_req_wdata : p1_req_wdata;

    // Output slot: loads only on accept, so fields hold while memory stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_req_valid <= 1'b0;
            m_req_addr  <= '0;
            m_req_we    <= 1'b0;
            m_req_wstrb <= '0;
            m_req_wdata <= '0;
            slot_port   <= PORT_P1;
            last_grant  <= PORT_P2;
        end else if (accept) begin
            m_req_valid <= 1'b1;
            m_req_addr  <= sel_addr;
            m_req_we    <= sel_we;
            m_req_wstrb <= sel_wstrb;
            m_req_wdata <= sel_wdata;
            slot_port   <= grant;
            last_grant  <= grant;
        end else if (push) begin
            m_req_valid <= 1'b0;
        end
    end

    // Route FIFO of owner IDs for requests memory has accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fifo_count       <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            route_id         <= '0;
            o_err_unexpected <= 1'b0;
        end else begin
            if (push) begin
                route_id[wr_ptr] <= slot_port;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (m_rsp_valid && fifo_empty) begin
                o_err_unexpected <= 1'b1;
            end
        end
    end

    assign p1_rsp_valid = pop && (head == PORT_P1);
    assign p2_rsp_valid = pop && (head == PORT_P2);
    assign p1_rsp_rdata = m_rsp_rdata;
    assign p2_rsp_rdata = m_rsp_rdata;

endmodule
